// File: rtl/ysyx_22050535_ctrl_if.sv
// ysyx_22050535_ctrl_if: handshake, decode-class, control and counter signals of the core control FSM
interface ysyx_22050535_ctrl_if;
    logic        start;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_we;
    logic        is_load;
    logic        is_store;
    logic        is_ebreak;
    logic        dmem_req;
    logic        dmem_ack;
    logic        pc_we;
    logic        rf_we;
    logic        halt;
    logic        err;
    logic [2:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] instret;
    modport master (
        output start, imem_ack, is_load, is_store, is_ebreak, dmem_ack,
        input  imem_req, ir_we, dmem_req, pc_we, rf_we, halt, err, state, cycle_cnt, instret
    );
    modport slave (
        input  start, imem_ack, is_load, is_store, is_ebreak, dmem_ack,
        output imem_req, ir_we, dmem_req, pc_we, rf_we, halt, err, state, cycle_cnt, instret
    );
endinterface

// File: rtl/ysyx_22050535_ctrl.sv
// ysyx_22050535_ctrl: multi-cycle core control FSM with bus timeout and performance counters
module ysyx_22050535_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_22050535_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR} state_t;
    state_t      state_q, state_d;
    logic [7:0]  wait_q;
    logic [31:0] cycle_q, instret_q;
    logic        waiting, acked;
    assign waiting = state_q == FETCH || state_q == MEM;
    assign acked   = state_q == FETCH ? bus.imem_ack : state_q == MEM ? bus.dmem_ack : 1'b0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= state_d != state_q ? 8'd0 : waiting && !acked ? wait_q + 8'd1 : wait_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (state_q >= FETCH && state_q <= WB) cycle_q <= cycle_q + 32'd1;
            if (state_q == WB || (state_q == DECODE && bus.is_ebreak)) instret_q <= instret_q + 32'd1;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? FETCH : IDLE;
            FETCH:   state_d = acked ? DECODE : wait_q == TIMEOUT ? ERROR : FETCH;
            DECODE:  state_d = bus.is_ebreak ? HALT : EXEC;
            EXEC:    state_d = bus.is_load || bus.is_store ? MEM : WB;
            MEM:     state_d = acked ? WB : wait_q == TIMEOUT ? ERROR : MEM;
            WB:      state_d = FETCH;
            default: state_d = state_q;
        endcase
    end
    always_comb begin
        bus.imem_req  = state_q == FETCH;
        bus.ir_we     = state_q == FETCH && bus.imem_ack;
        bus.dmem_req  = state_q == MEM;
        bus.pc_we     = state_q == WB;
        bus.rf_we     = state_q == WB && !bus.is_store;
        bus.halt      = state_q == HALT;
        bus.err       = state_q == ERROR;
        bus.state     = state_q;
        bus.cycle_cnt = cycle_q;
        bus.instret   = instret_q;
    end
endmodule

// File: tb/tb_ysyx_22050535_ctrl.sv
// tb_ysyx_22050535_ctrl: randomized instruction-level checks of the control FSM against a behavioural model
module tb_ysyx_22050535_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;
    int          n_chk = 0;
    int          n_pass = 0;
    ysyx_22050535_ctrl_if bus ();
    ysyx_22050535_ctrl #(.TIMEOUT(8'd4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    task automatic cyc(input logic [2:0] st, input logic ia, input logic da, input logic sv);
        logic [6:0] eo;
        bus.start = sv;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        #1;
        eo = {st == 3'd1, st == 3'd1 && ia, st == 3'd4, st == 3'd5, st == 3'd5 && !bus.is_store, st == 3'd6, st == 3'd7};
        check("state", 32'(bus.state), 32'(st));
        check("ctrl", 32'({bus.imem_req, bus.ir_we, bus.dmem_req, bus.pc_we, bus.rf_we, bus.halt, bus.err}), 32'(eo));
        check("cycle_cnt", bus.cycle_cnt, m_cyc);
        check("instret", bus.instret, m_ret);
        @(posedge clk);
        if (!rst) begin
            m_cyc = 32'd0;
            m_ret = 32'd0;
        end else begin
            if (st >= 3'd1 && st <= 3'd5) m_cyc = m_cyc + 32'd1;
            if (st == 3'd5 || (st == 3'd2 && bus.is_ebreak)) m_ret = m_ret + 32'd1;
        end
        #1;
    endtask
    task automatic run_instr(input int cls, input int fd, input int md);
        bus.is_load = cls == 1;
        bus.is_store = cls == 2;
        bus.is_ebreak = cls == 3;
        for (int i = 0; i < fd; i++) cyc(3'd1, 1'b0, rb(), rb());
        cyc(3'd1, 1'b1, rb(), rb());
        cyc(3'd2, rb(), rb(), rb());
        if (cls != 3) begin
            cyc(3'd3, rb(), rb(), rb());
            if (cls == 1 || cls == 2) begin
                for (int i = 0; i < md; i++) cyc(3'd4, rb(), 1'b0, rb());
                cyc(3'd4, rb(), 1'b1, rb());
            end
            cyc(3'd5, rb(), rb(), rb());
        end
    endtask
    initial begin
        {bus.start, bus.imem_ack, bus.dmem_ack, bus.is_load, bus.is_store, bus.is_ebreak} = '0;
        @(posedge clk);
        #1;
        cyc(3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(3'd0, 1'b0, 1'b0, 1'b0);
        cyc(3'd0, 1'b1, 1'b1, 1'b1);
        run_instr(0, 0, 0);
        run_instr(2, 0, 3);
        for (int n = 0; n < 40; n++) run_instr($urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 4));
        run_instr(3, $urandom_range(0, 2), 0);
        for (int i = 0; i < 5; i++) cyc(3'd6, rb(), rb(), rb());
        rst = 1'b0;
        cyc(3'd6, rb(), rb(), 1'b1);
        cyc(3'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(3'd1, 1'b0, rb(), rb());
        for (int i = 0; i < 5; i++) cyc(3'd7, rb(), rb(), rb());
        rst = 1'b0;
        cyc(3'd7, rb(), rb(), 1'b1);
        cyc(3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(3'd0, 1'b0, 1'b0, 1'b1);
        bus.is_load = 1'b1;
        bus.is_store = 1'b0;
        bus.is_ebreak = 1'b0;
        cyc(3'd1, 1'b1, 1'b0, 1'b0);
        cyc(3'd2, 1'b0, 1'b0, 1'b0);
        cyc(3'd3, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(3'd4, 1'b1, 1'b1, 1'b1);
        cyc(3'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(3'd0, 1'b0, 1'b0, 1'b1);
        force dut.instret_q = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        cyc(3'd1, 1'b0, 1'b0, 1'b0);
        release dut.instret_q;
        run_instr(0, 0, 0);
        cyc(3'd1, 1'b0, 1'b0, 1'b0);
        check("instret_wrap", bus.instret, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
